// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one 32-bit VRAM port between the VGA scan-out
// and a CPU. Display fetches win every 4th active pixel; CPU otherwise.
// Ports: clk, rst_n; H/V_Count_Value from vga_controller; cfg_vblank_only;
//   cpu_valid/we/addr/wdata -> cpu_ready, cpu_rvalid, cpu_rdata;
//   mem_en/we/addr/wdata -> VRAM, mem_rdata <- VRAM (1-cycle latency);
//   pixel_out/pixel_de -> display (2-cycle latency from the counters).
module vram_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        H_Count_Value,
   input  logic [9:0]        V_Count_Value,
   input  logic              cfg_vblank_only,
   input  logic              cpu_valid,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [7:0]        pixel_out,
   output logic              pixel_de
);

   localparam int unsigned       WPL       = H_ACTIVE / 4;
   localparam logic [9:0]        H_LIM     = 10'(H_ACTIVE);
   localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] MEM_WORDS = ADDR_W'(WPL * V_ACTIVE);

   logic              active;
   logic              slot;
   logic              cpu_ok;
   logic              cpu_oob;
   logic              cpu_rd;
   logic [ADDR_W-1:0] disp_addr;

   // pend: a read was issued last cycle; owner: 1 = it was the CPU's
   logic              pend_q,  pend_d;
   logic              owner_q, owner_d;
   logic              oob_q,   oob_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       word_q,  word_d;
   logic              act1_q,  act1_d;
   logic              act2_q,  act2_d;
   logic [1:0]        sel1_q,  sel1_d;
   logic [1:0]        sel2_q,  sel2_d;

   always_comb begin
      active  = (H_Count_Value < H_LIM) && (V_Count_Value < V_LIM);
      slot    = active && (H_Count_Value[1:0] == 2'd0);
      cpu_ok  = !cfg_vblank_only || (V_Count_Value >= V_LIM);
      cpu_ready = cpu_valid && !slot && cpu_ok;
      cpu_oob = cpu_addr >= MEM_WORDS;
      cpu_rd  = cpu_ready && !cpu_we;
   end

   // Line base = V * WPL, built from the set bits of WPL (no multiplier)
   always_comb begin
      disp_addr = ADDR_W'(H_Count_Value[9:2]);
      for (int i = 0; i < ADDR_W; i++) begin
         if (WPL[i]) begin
            disp_addr = disp_addr + (ADDR_W'(V_Count_Value) << i);
         end
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (slot) begin
         mem_en   = 1'b1;
         mem_addr = disp_addr;
      end else if (cpu_ready) begin
         // out-of-range writes are accepted but never reach memory
         mem_en = !(cpu_we && cpu_oob);
         mem_we = cpu_we && !cpu_oob;
      end
   end

   always_comb begin
      cpu_rvalid = pend_q && owner_q;
      cpu_rdata  = rdata_q;
      if (cpu_rvalid) begin
         cpu_rdata = oob_q ? 32'd0 : mem_rdata;
      end
      pixel_de  = act2_q;
      pixel_out = act2_q ? word_q[{sel2_q, 3'b000} +: 8] : 8'd0;
   end

   always_comb begin
      pend_d  = slot || cpu_rd;
      owner_d = !slot && cpu_rd;
      oob_d   = cpu_oob;
      rdata_d = cpu_rdata;
      word_d  = (pend_q && !owner_q) ? mem_rdata : word_q;
      act1_d  = active;
      sel1_d  = H_Count_Value[1:0];
      act2_d  = act1_q;
      sel2_d  = sel1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= 1'b0;
         owner_q <= 1'b0;
         oob_q   <= 1'b0;
         rdata_q <= 32'd0;
         word_q  <= 32'd0;
         act1_q  <= 1'b0;
         act2_q  <= 1'b0;
         sel1_q  <= 2'd0;
         sel2_q  <= 2'd0;
      end else begin
         pend_q  <= pend_d;
         owner_q <= owner_d;
         oob_q   <= oob_d;
         rdata_q <= rdata_d;
         word_q  <= word_d;
         act1_q  <= act1_d;
         act2_q  <= act2_d;
         sel1_q  <= sel1_d;
         sel2_q  <= sel2_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed vector table for the arbitration
// logic plus hand-written sequences for reads, pixels and reset.
module tb_vram_arbiter;

   localparam logic [31:0] W0  = 32'h4433_2211;
   localparam logic [31:0] W1  = 32'h8877_6655;
   localparam logic [31:0] W3  = 32'hCAFE_F00D;
   localparam logic [31:0] WOB = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  h_cnt, v_cnt;
   logic        vblank, cpu_valid, cpu_we;
   logic [16:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        mem_en, mem_we;
   logic [16:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic [7:0]  pixel_out;
   logic        pixel_de;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .H_Count_Value(h_cnt), .V_Count_Value(v_cnt),
      .cfg_vblank_only(vblank),
      .cpu_valid(cpu_valid), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .pixel_out(pixel_out), .pixel_de(pixel_de)
   );

   // VRAM model: synchronous, 1-cycle read latency
   logic [31:0] mem [0:131071];
   bit loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         mem[0]     <= W0;
         mem[1]     <= W1;
         mem[3]     <= W3;
         for (int k = 0; k < 4; k++)
            mem[10+k] <= 32'h1000_0000 + 32'(k) * 32'h111;
         mem[76800] <= WOB;
         loaded     <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic [9:0]  h, v;
      logic        vb, val, we;
      logic [16:0] addr;
      logic [31:0] wd;
      logic        rdy, en, mwe, chk_a;
      logic [16:0] ma;
   } vec_t;

   vec_t vt [12];

   task automatic setv(input int i, input int h, input int v,
                       input int vb, input int val, input int we,
                       input int addr, input int wd, input int rdy,
                       input int en, input int mwe, input int ca,
                       input int ma);
      vt[i].h = 10'(h);     vt[i].v = 10'(v);
      vt[i].vb = 1'(vb);    vt[i].val = 1'(val);
      vt[i].we = 1'(we);    vt[i].addr = 17'(addr);
      vt[i].wd = 32'(wd);   vt[i].rdy = 1'(rdy);
      vt[i].en = 1'(en);    vt[i].mwe = 1'(mwe);
      vt[i].chk_a = 1'(ca); vt[i].ma = 17'(ma);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input int h, input int v, input int vb,
                        input int val, input int we, input int addr,
                        input int wd);
      h_cnt = 10'(h); v_cnt = 10'(v); vblank = 1'(vb);
      cpu_valid = 1'(val); cpu_we = 1'(we);
      cpu_addr = 17'(addr); cpu_wdata = 32'(wd);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w;
      int k;

      setv(0,    0,   0, 0, 1, 0,     5,           0, 0, 1, 0, 1,     0);
      setv(1,    1,   0, 0, 1, 0,     5,           0, 1, 1, 0, 1,     5);
      setv(2,    8,   1, 0, 0, 0,     0,           0, 0, 1, 0, 1,   162);
      setv(3,  636, 479, 0, 1, 1,     7,           0, 0, 1, 0, 1, 76799);
      setv(4,  641, 100, 1, 1, 0,     5,           0, 0, 0, 0, 0,     0);
      setv(5,  641, 100, 0, 1, 1,  1234, 32'h5A5AA5A5, 1, 1, 1, 1,  1234);
      setv(6,    0, 480, 1, 1, 0,     9,           0, 1, 1, 0, 1,     9);
      setv(7,    4, 480, 1, 1, 1, 76800,   32'h1234, 1, 0, 0, 0,     0);
      setv(8,    3,   2, 0, 0, 0,     0,           0, 0, 0, 0, 0,     0);
      setv(9,  640,   0, 0, 0, 0,     0,           0, 0, 0, 0, 0,     0);
      setv(10,   2,   0, 1, 1, 0,     5,           0, 0, 0, 0, 0,     0);
      setv(11,  12,   2, 0, 1, 1,    20,           0, 0, 1, 0, 1,   323);

      rst_n = 1'b0;
      drive(700, 0, 0, 0, 0, 0, 0);
      repeat (3) next();
      #3;
      chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_rdata",  cpu_rdata,       32'd0);
      chk("rst_de",     32'(pixel_de),   32'd0);
      chk("rst_pix",    32'(pixel_out),  32'd0);
      next();
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         next();
         drive(vt[i].h, vt[i].v, vt[i].vb, vt[i].val, vt[i].we,
               vt[i].addr, vt[i].wd);
         #3;
         chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'(vt[i].rdy));
         chk($sformatf("v%0d_en", i),    32'(mem_en),    32'(vt[i].en));
         chk($sformatf("v%0d_we", i),    32'(mem_we),    32'(vt[i].mwe));
         if (vt[i].chk_a)
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vt[i].ma));
         if (vt[i].mwe)
            chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].wd);
      end

      // vblank-only mode: back-to-back reads accepted every cycle
      for (int i = 0; i < 5; i++) begin
         next();
         drive(700 + i, 480, 1, (i < 4) ? 1 : 0, 0, 10 + i, 0);
         #3;
         chk($sformatf("b2b%0d_ready", i), 32'(cpu_ready),
             (i < 4) ? 32'd1 : 32'd0);
         if (i > 0) begin
            chk($sformatf("b2b%0d_rvalid", i), 32'(cpu_rvalid), 32'd1);
            chk($sformatf("b2b%0d_rdata", i), cpu_rdata,
                32'h1000_0000 + 32'(i - 1) * 32'h111);
         end
      end

      // out-of-range read returns zero
      next();
      drive(700, 480, 0, 1, 0, 76800, 0);
      #3;
      chk("oob_ready", 32'(cpu_ready), 32'd1);
      next();
      drive(700, 480, 0, 0, 0, 0, 0);
      #3;
      chk("oob_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("oob_rdata",  cpu_rdata,       32'd0);
      next();
      #3;
      chk("oob_rv_once", 32'(cpu_rvalid), 32'd0);

      // reset right after an accepted read drops the response
      next();
      drive(5, 480, 0, 1, 0, 3, 0);
      #3;
      chk("mid_ready", 32'(cpu_ready), 32'd1);
      next();
      rst_n = 1'b0;
      drive(700, 0, 0, 0, 0, 0, 0);
      #3;
      chk("mid_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("mid_rdata",  cpu_rdata,       32'd0);
      chk("mid_pix",    32'(pixel_out),  32'd0);
      chk("mid_de",     32'(pixel_de),   32'd0);
      next();
      rst_n = 1'b1;
      #3;
      chk("post_rvalid", 32'(cpu_rvalid), 32'd0);
      next();

      // line 0 scan-out with a CPU read interleaved at H=1
      for (int n = 0; n < 10; n++) begin
         next();
         drive(n, 0, 0, (n <= 1) ? 1 : 0, 0, 3, 0);
         #3;
         if (n == 0) begin
            chk("s_h0_ready", 32'(cpu_ready), 32'd0);
            chk("s_h0_addr",  32'(mem_addr),  32'd0);
         end
         if (n == 1) begin
            chk("s_h1_ready", 32'(cpu_ready), 32'd1);
            chk("s_h1_addr",  32'(mem_addr),  32'd3);
         end
         chk($sformatf("s%0d_rvalid", n), 32'(cpu_rvalid),
             (n == 2) ? 32'd1 : 32'd0);
         if (n == 2 || n == 3)
            chk($sformatf("s%0d_rdata", n), cpu_rdata, W3);
         chk($sformatf("s%0d_de", n), 32'(pixel_de),
             (n >= 2) ? 32'd1 : 32'd0);
         if (n >= 2) begin
            k = n - 2;
            w = (k < 4) ? W0 : W1;
            w = w >> (8 * (k % 4));
            chk($sformatf("s%0d_pix", n), 32'(pixel_out), {24'd0, w[7:0]});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ADDR_W, 17, word address width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- H_Count_Value, in, 10, horizontal counter from vga_controller; advances by 1 per clk.
- V_Count_Value, in, 10, vertical counter from vga_controller.
- cfg_vblank_only, in, 1, 1 = CPU is granted only during vertical blanking.
- cpu_valid, in, 1, CPU request present.
- cpu_we, in, 1, 1 = write, 0 = read.
- cpu_addr, in, ADDR_W, CPU word address.
- cpu_wdata, in, 32, CPU write data.
- cpu_ready, out, 1, request accepted this cycle.
- cpu_rvalid, out, 1, read data valid.
- cpu_rdata, out, 32, read data.
- mem_en, out, 1, memory access strobe.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory word address.
- mem_wdata, out, 32, memory write data.
- mem_rdata, in, 32, memory read data, valid 1 cycle after a read strobe.
- pixel_out, out, 8, pixel for the display.
- pixel_de, out, 1, display-enable aligned with pixel_out.

Function
REQ-003 Memory word SHALL hold 4 pixels; byte n (bits 8n+7:8n) is pixel 4k+n.
REQ-004 Active region SHALL be H_Count_Value < H_ACTIVE and V_Count_Value < V_ACTIVE.
REQ-005 Display slot SHALL be active AND H_Count_Value[1:0]==0.
REQ-006 In a display slot the block SHALL drive mem_en=1, mem_we=0, mem_addr = V*(H_ACTIVE/4) + H[9:2], computed with shift/add only.
REQ-007 The display slot SHALL have absolute priority.
- cpu_ready SHALL be 0 in that cycle regardless of cpu_valid.
REQ-008 cpu_ready SHALL be combinational: cpu_valid AND NOT display slot AND (NOT cfg_vblank_only OR V_Count_Value >= V_ACTIVE).
REQ-009 On cpu_valid && cpu_ready the block SHALL drive mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
REQ-010 With no display slot and no accepted CPU request, mem_en and mem_we SHALL be 0.
REQ-011 A CPU request not accepted SHALL be held by the requester; the block SHALL NOT latch it.
REQ-012 CPU address >= (H_ACTIVE/4)*V_ACTIVE:
- write SHALL be accepted with mem_en=0 (dropped).
- read SHALL be accepted and return cpu_rdata=0.
REQ-013 An accepted CPU read SHALL produce cpu_rvalid=1 for exactly 1 cycle, 1 cycle after acceptance, with cpu_rdata=mem_rdata (or 0 per REQ-012).
- Otherwise cpu_rvalid=0 and cpu_rdata holds its last value.
REQ-014 A 1-bit owner register SHALL route mem_rdata.
- Display reads SHALL never assert cpu_rvalid.
- CPU reads SHALL never load the display word register.
REQ-015 Display read data SHALL be captured into a 32-bit word register the cycle after the slot.
REQ-016 Pixel pipeline latency SHALL be exactly 2 clk:
- pixel_de(t+2) = active(t).
- pixel_out(t+2) = byte H(t)[1:0] of the word register when active(t), else 0.
REQ-017 Back-to-back CPU requests SHALL be accepted every non-slot cycle (full throughput outside display slots).

Reset
REQ-018 While rst_n=0 the block SHALL force these outputs and registers to 0:
- cpu_rvalid, cpu_rdata, pixel_out, pixel_de, word register, owner, pipeline registers.
- Combinational mem_* and cpu_ready follow REQ-006..REQ-010 from the inputs.
REQ-019 Reset mid-transaction SHALL discard any pending cpu_rvalid.
REQ-020 After rst_n deasserts the block SHALL need no warm-up; the first active slot SHALL fetch normally.

Verification
REQ-021 H=0,V=0, cpu_valid=1 read -> mem_addr=0, cpu_ready=0; at H=1 cpu_ready=1; cpu_rvalid=1 at H=2.
REQ-022 Memory word 0x44332211 at address 0, line 0 -> pixel_out 0x11,0x22,0x33,0x44 at H(t)=0..3 delayed 2 cycles; pixel_de=1.
REQ-023 V=1,H=8 -> mem_addr=162; V=479,H=636 -> mem_addr=76799.
REQ-024 cfg_vblank_only=1, V=100, H=641, cpu_valid=1 -> cpu_ready=0; V=480 -> cpu_ready=1 every cycle.
REQ-025 CPU write to 76800 -> cpu_ready=1, mem_en=0; read of 76800 -> cpu_rvalid=1, cpu_rdata=0.
REQ-026 Accept CPU read, assert rst_n=0 next cycle -> cpu_rvalid stays 0, pixel_out=0, pixel_de=0.
